stream_framer: RTL and testbench

STREAM_FRAMER -- requirements
Module: stream_framer

---
 rtl/stream_framer.sv | 169 ++++++++++++++++
 tb/tb_stream_framer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_framer.sv
// stream_framer: cuts a continuous sample stream into packets of spp samples.
// Ports: clk, reset_n, clear, spp, timeout, i_t* (input stream),
//   o_t* (packetized output), pkt_count, flush_count.
module stream_framer #(
    parameter int WIDTH    = 16,
    parameter int SPP_LOG2 = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [SPP_LOG2-1:0] spp,
    input  logic [15:0]         timeout,
    input  logic [WIDTH-1:0]    i_tdata,
    input  logic                i_tvalid,
    output logic                i_tready,
    output logic [WIDTH-1:0]    o_tdata,
    output logic                o_tlast,
    output logic                o_tvalid,
    input  logic                o_tready,
    output logic [31:0]         pkt_count,
    output logic [15:0]         flush_count
);

    logic [WIDTH-1:0]    h_data_q, h_data_d;
    logic                h_last_q, h_last_d;
    logic                h_valid_q, h_valid_d;
    logic [WIDTH-1:0]    o_data_q, o_data_d;
    logic                o_last_q, o_last_d;
    logic                o_valid_q, o_valid_d;
    logic [SPP_LOG2-1:0] cnt_q, cnt_d;
    logic [SPP_LOG2-1:0] spp_lat_q, spp_lat_d;
    logic [15:0]         idle_q, idle_d;
    logic [31:0]         pkt_q, pkt_d;
    logic [15:0]         flush_q, flush_d;

    logic                o_free;
    logic                fire_raw;
    logic                fire;
    logic                release_h;
    logic                accept;
    logic                new_last;
    logic [SPP_LOG2-1:0] spp_new;
    logic [SPP_LOG2-1:0] spp_cur;

    assign o_free   = !o_valid_q || o_tready;

    // Timeout candidate, independent of accept so that the ready path
    // has no combinational loop; an accept in the same cycle cancels it.
    assign fire_raw = (timeout != 16'd0) && h_valid_q && !h_last_q &&
                      (idle_q == timeout - 16'd1);

    // When i_tvalid is high and O is free, the input is guaranteed to be
    // accepted, so i_tvalid stands in for "accept" in the release term.
    assign release_h = h_valid_q && o_free &&
                       (h_last_q || i_tvalid || fire_raw);

    assign i_tready = reset_n && (!h_valid_q || release_h);
    assign accept   = i_tvalid && i_tready;
    assign fire     = fire_raw && !accept;

    // spp of 0 behaves as 1; a new packet uses the live spp value.
    assign spp_new  = (spp == '0) ? SPP_LOG2'(1) : spp;
    assign spp_cur  = (cnt_q == '0) ? spp_new : spp_lat_q;
    assign new_last = (cnt_q == spp_cur - SPP_LOG2'(1));

    always_comb begin
        h_data_d  = h_data_q;
        h_last_d  = h_last_q;
        h_valid_d = h_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        o_valid_d = o_valid_q;
        cnt_d     = cnt_q;
        spp_lat_d = spp_lat_q;
        idle_d    = idle_q;
        pkt_d     = pkt_q;
        flush_d   = flush_q;

        if (release_h) begin
            o_data_d  = h_data_q;
            o_last_d  = h_last_q || fire;
            o_valid_d = 1'b1;
        end else if (o_valid_q && o_tready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            h_data_d  = i_tdata;
            h_last_d  = new_last;
            h_valid_d = 1'b1;
        end else if (release_h) begin
            h_valid_d = 1'b0;
            h_last_d  = 1'b0;
        end else if (fire) begin
            // O blocked: mark the held sample as the packet end.
            h_last_d  = 1'b1;
        end

        if (accept) begin
            cnt_d = new_last ? '0 : cnt_q + SPP_LOG2'(1);
            if (cnt_q == '0) begin
                spp_lat_d = spp_new;
            end
        end else if (fire) begin
            cnt_d = '0;
        end

        if (h_valid_q && !h_last_q && !accept && !fire) begin
            idle_d = idle_q + 16'd1;
        end else begin
            idle_d = 16'd0;
        end

        if (o_valid_q && o_tready && o_last_q) begin
            pkt_d = pkt_q + 32'd1;
        end

        if (fire && flush_q != 16'hFFFF) begin
            flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_data_q  <= '0;
            h_last_q  <= 1'b0;
            h_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
            cnt_q     <= '0;
            spp_lat_q <= SPP_LOG2'(1);
            idle_q    <= 16'd0;
            pkt_q     <= 32'd0;
            flush_q   <= 16'd0;
        end else if (clear) begin
            h_data_q  <= '0;
            h_last_q  <= 1'b0;
            h_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
            cnt_q     <= '0;
            spp_lat_q <= SPP_LOG2'(1);
            idle_q    <= 16'd0;
            pkt_q     <= 32'd0;
            flush_q   <= 16'd0;
        end else begin
            h_data_q  <= h_data_d;
            h_last_q  <= h_last_d;
            h_valid_q <= h_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_valid_q <= o_valid_d;
            cnt_q     <= cnt_d;
            spp_lat_q <= spp_lat_d;
            idle_q    <= idle_d;
            pkt_q     <= pkt_d;
            flush_q   <= flush_d;
        end
    end

    assign o_tdata     = o_data_q;
    assign o_tlast     = o_last_q;
    assign o_tvalid    = o_valid_q;
    assign pkt_count   = pkt_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: random and directed stimulus for stream_framer,
// checked every cycle against a packet-level reference model.
module tb_stream_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [9:0]  spp;
    logic [15:0] timeout;
    logic [15:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] pkt_count;
    logic [15:0] flush_count;

    stream_framer #(.WIDTH(16), .SPP_LOG2(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .spp         (spp),
        .timeout     (timeout),
        .i_tdata     (i_tdata),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .pkt_count   (pkt_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Reference model state
    logic [16:0] exp_q[$];
    int          lens[$];
    int          acc_at[int];
    int          out_at[int];
    int          cyc = 0;
    int          pos = 0;
    int          cur = 1;
    int          idle = 0;
    bit          pend = 0;
    int          plen = 0;
    logic [31:0] m_pkt = 0;
    logic [15:0] m_flush = 0;
    bit          stall = 0;
    logic [15:0] st_d;
    logic        st_l;
    bit          rand_rdy = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        logic [16:0] e;
        logic        lst;
        cyc++;
        if (!reset_n || clear) begin
            exp_q.delete();
            pos = 0; pend = 0; idle = 0; plen = 0;
            m_pkt = 0; m_flush = 0; stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(o_tvalid), 32'd1);
                chk("hold_data", 32'(o_tdata), 32'(st_d));
                chk("hold_last", 32'(o_tlast), 32'(st_l));
            end
            chk("pkt_count", pkt_count, m_pkt);
            chk("flush_count", 32'(flush_count), 32'(m_flush));
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    vec++; errs++;
                    $display("FAIL extra_out: got %0h expected none", o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(o_tdata), 32'(e[15:0]));
                    chk("out_last", 32'(o_tlast), 32'(e[16]));
                    out_at[int'(o_tdata)] = cyc;
                    plen++;
                    if (o_tlast) begin
                        lens.push_back(plen);
                        plen = 0;
                        m_pkt = m_pkt + 1;
                    end
                end
            end
            stall = o_tvalid && !o_tready;
            st_d  = o_tdata;
            st_l  = o_tlast;
            if (i_tvalid && i_tready) begin
                if (pos == 0) cur = (spp == 0) ? 1 : int'(spp);
                lst = (pos == cur - 1);
                exp_q.push_back({lst, i_tdata});
                acc_at[int'(i_tdata)] = cyc;
                pos  = lst ? 0 : pos + 1;
                pend = !lst;
                idle = 0;
            end else if (pend && timeout != 0) begin
                idle++;
                if (idle == int'(timeout)) begin
                    e = exp_q[exp_q.size()-1];
                    exp_q[exp_q.size()-1] = e | 17'h10000;
                    pos = 0; pend = 0; idle = 0;
                    if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
                end
            end
        end
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        @(negedge clk);
        while (!i_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            vec++; errs++;
            $display("FAIL send_wait: got stuck expected accept");
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 2000) begin
            vec++; errs++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
    endtask

    initial begin
        int bad;
        reset_n  = 1'b0;
        clear    = 1'b0;
        spp      = 10'd4;
        timeout  = 16'd0;
        i_tvalid = 1'b0;
        i_tdata  = 16'd0;
        o_tready = 1'b1;
        #1;
        chk("rst_tready", 32'(i_tready), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_ovalid", 32'(o_tvalid), 32'd0);
        chk("rst_odata", 32'(o_tdata), 32'd0);
        chk("rst_olast", 32'(o_tlast), 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_tready", 32'(i_tready), 32'd1);
        @(posedge clk);
        #1;

        // Three full packets of 4
        lens.delete();
        for (int d = 1; d <= 12; d++) send(16'(d));
        drain();
        chk("t1_pkt", pkt_count, 32'd3);
        chk("t1_npk", 32'(lens.size()), 32'd3);
        for (int i = 0; i < lens.size(); i++) chk("t1_len", 32'(lens[i]), 32'd4);
        chk("t1_lat", 32'(out_at[4] - acc_at[4]), 32'd2);

        // Timeout closes a partial packet
        timeout = 16'd5;
        lens.delete();
        for (int d = 1; d <= 6; d++) send(16'(d));
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t2_flush", 32'(flush_count), 32'd1);
        chk("t2_pkt", pkt_count, 32'd5);
        chk("t2_npk", 32'(lens.size()), 32'd2);
        if (lens.size() == 2) begin
            chk("t2_len0", 32'(lens[0]), 32'd4);
            chk("t2_len1", 32'(lens[1]), 32'd2);
        end
        chk("t2_lat", 32'(out_at[6] - acc_at[6]), 32'd6);

        // Random valid/ready
        timeout  = 16'd0;
        spp      = 10'd3;
        rand_rdy = 1'b1;
        lens.delete();
        for (int i = 0; i < 3000; i++) begin
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #0;
            send(16'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        foreach (lens[i]) if (lens[i] != 3) bad++;
        chk("t3_npk", 32'(lens.size()), 32'd1000);
        chk("t3_badlen", 32'(bad), 32'd0);

        // spp change mid-packet
        spp = 10'd4;
        lens.delete();
        send(16'd1);
        send(16'd2);
        spp = 10'd2;
        for (int d = 3; d <= 8; d++) send(16'(d));
        drain();
        chk("t4_npk", 32'(lens.size()), 32'd3);
        if (lens.size() == 3) begin
            chk("t4_len0", 32'(lens[0]), 32'd4);
            chk("t4_len1", 32'(lens[1]), 32'd2);
            chk("t4_len2", 32'(lens[2]), 32'd2);
        end

        // Reset mid-packet
        spp = 10'd4;
        send(16'd1);
        send(16'd2);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_tready", 32'(i_tready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_tready", 32'(i_tready), 32'd1);
        chk("t5_pkt0", pkt_count, 32'd0);
        chk("t5_flush0", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        lens.delete();
        for (int d = 11; d <= 14; d++) send(16'(d));
        drain();
        chk("t5_pkt", pkt_count, 32'd1);
        chk("t5_npk", 32'(lens.size()), 32'd1);
        if (lens.size() == 1) chk("t5_len", 32'(lens[0]), 32'd4);

        // spp of 0 behaves as 1
        spp = 10'd0;
        lens.delete();
        send(16'd7);
        send(16'd8);
        drain();
        chk("t6_pkt", pkt_count, 32'd3);
        chk("t6_npk", 32'(lens.size()), 32'd2);
        foreach (lens[i]) chk("t6_len", 32'(lens[i]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
